lcd_init_ctrl: RTL and testbench
================================

LCD_INIT_CTRL -- requirements
Module: lcd_init_ctrl

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 480_000, post-command wait in clk cycles (120 ms at 4 MHz).
REQ-002 SHALL have parameter RST_PULSE_VAL, default LOW (0), level driven on o_reset_val during hardware reset.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port i_start, input, 1, single-cycle request to run the init sequence.
REQ-006 SHALL have port i_reset_sent, input, 1, one-cycle done pulse from the panel reset block.
REQ-007 SHALL have port o_reset_ena, output, 1, one-cycle launch pulse to the panel reset block.
REQ-008 SHALL have port o_reset_val, output, 1, reset level forwarded to the reset block.
REQ-009 SHALL have port o_spi_valid, output, 1, byte available to the SPI transmitter.
REQ-010 SHALL have port i_spi_ready, input, 1, transmitter accepts the byte this cycle.
REQ-011 SHALL have port o_spi_dc, output, 1, 0 = command, 1 = data.
REQ-012 SHALL have port o_spi_data, output, 8, byte to transmit.
REQ-013 SHALL have port o_busy, output, 1, high from start acceptance until DONE.
REQ-014 SHALL have port o_init_done, output, 1, sticky high once the sequence completes.

Function
REQ-015 SHALL implement states IDLE, HW_RESET, WAIT_RST, LOAD, SEND, DELAY, DONE.
REQ-016 IDLE: i_start=1 SHALL move to HW_RESET; i_start is ignored in all other states.
REQ-017 HW_RESET: SHALL assert o_reset_ena=1 and o_reset_val=RST_PULSE_VAL for exactly 1 cycle, then go to WAIT_RST.
REQ-018 WAIT_RST: SHALL hold o_reset_val=RST_PULSE_VAL until i_reset_sent=1, then clear the ROM index to 0 and go to LOAD.
REQ-019 o_reset_val SHALL be HIGH in all states other than HW_RESET and WAIT_RST.
REQ-020 LOAD: SHALL take 1 cycle to register the ROM entry at the current index; each entry is {kind[1:0], byte[7:0]} with kind CMD, DATA, WAIT or END.
REQ-021 CMD and DATA entries SHALL go to SEND; WAIT SHALL go to DELAY; END SHALL go to DONE.
REQ-022 SEND: SHALL hold o_spi_valid=1 with o_spi_dc and o_spi_data stable until i_spi_ready=1, which completes the transfer.
REQ-023 On transfer in SEND, the block SHALL increment the index and return to LOAD; o_spi_valid SHALL drop for at least the LOAD cycle.
REQ-024 DELAY: SHALL load the counter with DELAY_CYCLES-1, decrement it each cycle, and on the cycle it equals 0 increment the index and go to LOAD (DELAY_CYCLES cycles total).
REQ-025 Counter width SHALL be $clog2(DELAY_CYCLES); it holds its value outside DELAY.
REQ-026 DONE: SHALL set o_init_done=1 (sticky until reset), drop o_busy, and return to IDLE next cycle.
REQ-027 A new i_start after completion SHALL rerun the whole sequence; o_init_done SHALL stay high throughout the rerun.
REQ-028 The ROM index SHALL be 4 bits wide; an index that runs past the last entry SHALL read as END and never wrap.
REQ-029 ROM order SHALL be: CMD 0x01, WAIT, CMD 0x11, WAIT, CMD 0x3A, DATA 0x55, CMD 0x36, DATA 0x48, CMD 0x29, END.

Reset
REQ-030 With rst=0 on a clock edge, the block SHALL enter IDLE; set index=0 and counter=0; and drive o_reset_ena=0, o_reset_val=HIGH, o_spi_valid=0, o_spi_dc=0, o_spi_data=0x00, o_busy=0, o_init_done=0.
REQ-031 A reset in any state, including mid-SEND or mid-DELAY, SHALL abort the sequence with no further bytes presented.

Configuration
REQ-032 With macro INIT_SLEEP_WAIT_EN defined, WAIT entries SHALL behave as in REQ-024.
REQ-033 Without INIT_SLEEP_WAIT_EN, each WAIT entry SHALL take exactly 1 DELAY cycle, for fast simulation.

Structure
REQ-034 pkg_ili9341 SHALL hold the entry-kind enum, the entry struct typedef, the command constants (SWRESET, SLPOUT, COLMOD, MADCTL, DISPON) and the init table length.
REQ-035 The ROM SHALL be a sub-module init_rom: combinational, taking a 4-bit index and returning an entry.

Verification
REQ-036 Start after reset, i_reset_sent pulsed 5 cycles later: expect exactly one o_reset_ena pulse, o_reset_val=0 until i_reset_sent, then o_busy=1.
REQ-037 With i_spi_ready tied to 1: expect bytes in order 01,11,3A,55,36,48,29 with dc 0,0,0,1,0,1,0, then o_init_done=1.
REQ-038 Hold i_spi_ready=0 for 7 cycles on byte 0x3A: expect o_spi_valid and data held stable, and no byte skipped or repeated.
REQ-039 With INIT_SLEEP_WAIT_EN and DELAY_CYCLES=8: expect exactly 8 DELAY cycles between byte 0x01 acceptance and the LOAD of the 0x11 entry.
REQ-040 Assert rst=0 during the first DELAY, then restart: expect all outputs at reset values and a full sequence from 0x01.
REQ-041 Pulse i_start during SEND: expect it ignored, and exactly one sequence to complete.

Source files
------------

// File: rtl/pkg_ili9341.sv
// Shared types and constants for the ILI9341 power-up sequencer and its command ROM.
package pkg_ili9341;

  typedef enum logic [1:0] {
    KIND_CMD  = 2'd0,
    KIND_DATA = 2'd1,
    KIND_WAIT = 2'd2,
    KIND_END  = 2'd3
  } entry_kind_e;

  typedef struct packed {
    entry_kind_e kind;
    logic [7:0]  data;
  } init_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HW_RESET,
    ST_WAIT_RST,
    ST_LOAD,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } init_state_e;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;

  localparam logic [7:0] DATA_COLMOD_16BPP  = 8'h55;
  localparam logic [7:0] DATA_MADCTL_MX_BGR = 8'h48;

  localparam int unsigned INIT_LEN = 10;

  // Saturating step so a runaway index parks on an END slot instead of wrapping to 0.
  function automatic logic [3:0] next_index(input logic [3:0] idx);
    return (idx == 4'hF) ? idx : idx + 4'd1;
  endfunction

endpackage

// File: rtl/init_rom.sv
// Combinational init table for the ILI9341; every slot beyond the table reads as END.
module init_rom
  import pkg_ili9341::*;
(
  input  logic [3:0]  index_i,
  output init_entry_t entry_o
);

  always_comb begin
    entry_o = '{kind: KIND_END, data: 8'h00};
    case (index_i)
      4'd0:    entry_o = '{kind: KIND_CMD,  data: CMD_SWRESET};
      4'd1:    entry_o = '{kind: KIND_WAIT, data: 8'h00};
      4'd2:    entry_o = '{kind: KIND_CMD,  data: CMD_SLPOUT};
      4'd3:    entry_o = '{kind: KIND_WAIT, data: 8'h00};
      4'd4:    entry_o = '{kind: KIND_CMD,  data: CMD_COLMOD};
      4'd5:    entry_o = '{kind: KIND_DATA, data: DATA_COLMOD_16BPP};
      4'd6:    entry_o = '{kind: KIND_CMD,  data: CMD_MADCTL};
      4'd7:    entry_o = '{kind: KIND_DATA, data: DATA_MADCTL_MX_BGR};
      4'd8:    entry_o = '{kind: KIND_CMD,  data: CMD_DISPON};
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_init_ctrl.sv
// ILI9341 init sequencer: panel hardware reset, then ROM-driven command/data/wait playback.
// Define INIT_SLEEP_WAIT_EN for full-length WAIT entries; otherwise each WAIT lasts one cycle.
module lcd_init_ctrl
  import pkg_ili9341::*;
#(
  parameter int unsigned DELAY_CYCLES  = 480_000,
  parameter logic        RST_PULSE_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_reset_sent,
  output logic       o_reset_ena,
  output logic       o_reset_val,
  output logic       o_spi_valid,
  input  logic       i_spi_ready,
  output logic       o_spi_dc,
  output logic [7:0] o_spi_data,
  output logic       o_busy,
  output logic       o_init_done
);

  localparam int unsigned CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

`ifdef INIT_SLEEP_WAIT_EN
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DELAY_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] WAIT_LOAD = '0;
`endif

  init_state_e      state_q, state_d;
  logic [3:0]       index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  init_entry_t      entry_q, entry_d;
  logic             done_q, done_d;
  init_entry_t      rom_entry;

  init_rom u_rom (
    .index_i (index_q),
    .entry_o (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE:     if (i_start) state_d = ST_HW_RESET;
      ST_HW_RESET: state_d = ST_WAIT_RST;
      ST_WAIT_RST: begin
        if (i_reset_sent) begin
          index_d = '0;
          state_d = ST_LOAD;
        end
      end
      // The branch decision uses the ROM output directly; entry_q feeds the SPI outputs later.
      ST_LOAD: begin
        entry_d = rom_entry;
        case (rom_entry.kind)
          KIND_CMD, KIND_DATA: state_d = ST_SEND;
          KIND_WAIT: begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_DELAY;
          end
          default: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_SEND: begin
        if (i_spi_ready) begin
          index_d = next_index(index_q);
          state_d = ST_LOAD;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          index_d = next_index(index_q);
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign o_reset_ena = (state_q == ST_HW_RESET);
  assign o_reset_val = (state_q == ST_HW_RESET || state_q == ST_WAIT_RST) ? RST_PULSE_VAL : 1'b1;
  assign o_spi_valid = (state_q == ST_SEND);
  assign o_spi_dc    = (state_q == ST_SEND) && (entry_q.kind == KIND_DATA);
  assign o_spi_data  = (state_q == ST_SEND) ? entry_q.data : 8'h00;
  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_init_done = done_q;

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Scoreboard bench for lcd_init_ctrl: expected {dc,byte} words are queued at start and
// popped as the SPI handshake completes; covers reset, stalls, mid-DELAY abort and stray starts.
module tb_lcd_init_ctrl;

  localparam int unsigned DELAY = 8;
`ifdef INIT_SLEEP_WAIT_EN
  localparam int EXP_WAIT = DELAY;
`else
  localparam int EXP_WAIT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resetSent;
  logic       resetEna;
  logic       resetVal;
  logic       spiValid;
  logic       spiReady;
  logic       spiDc;
  logic [7:0] spiData;
  logic       busy;
  logic       initDone;

  lcd_init_ctrl #(
    .DELAY_CYCLES  (DELAY),
    .RST_PULSE_VAL (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_reset_sent (resetSent),
    .o_reset_ena  (resetEna),
    .o_reset_val  (resetVal),
    .o_spi_valid  (spiValid),
    .i_spi_ready  (spiReady),
    .o_spi_dc     (spiDc),
    .o_spi_data   (spiData),
    .o_busy       (busy),
    .o_init_done  (initDone)
  );

  always #5 clk = ~clk;

  logic [8:0] expQ[$];
  int         compareCount = 0;
  int         failCount    = 0;
  int         resetEnaCount = 0;
  int         stallSeen = 0;
  int         gap = 0;
  int         gapMeasured = -1;
  logic       gapCounting = 1'b0;
  logic       prevStall = 1'b0;
  logic [8:0] prevWord = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard side: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (resetEna) resetEnaCount++;
      if (prevStall) begin
        checkOutput("stall valid held", 32'(spiValid), 32'd1);
        checkOutput("stall word held", 32'({spiDc, spiData}), 32'(prevWord));
      end
      if (gapCounting) begin
        if (spiValid) begin
          gapMeasured = gap;
          gapCounting = 1'b0;
        end else begin
          gap++;
        end
      end
      if (spiValid && spiReady) begin
        if (expQ.size() == 0) begin
          checkOutput("extra byte", 32'({spiDc, spiData}), 32'hFFFF_FFFF);
        end else begin
          checkOutput("byte order", 32'({spiDc, spiData}), 32'(expQ.pop_front()));
        end
        if ({spiDc, spiData} == 9'h001) begin
          gapCounting = 1'b1;
          gap = 0;
        end
      end
      if (spiValid && !spiReady) stallSeen++;
      prevStall = spiValid && !spiReady;
      prevWord  = {spiDc, spiData};
    end else begin
      prevStall   = 1'b0;
      gapCounting = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " reset_ena"}, 32'(resetEna), 32'd0);
    checkOutput({tag, " reset_val"}, 32'(resetVal), 32'd1);
    checkOutput({tag, " spi_valid"}, 32'(spiValid), 32'd0);
    checkOutput({tag, " spi_dc"},    32'(spiDc),    32'd0);
    checkOutput({tag, " spi_data"},  32'(spiData),  32'd0);
    checkOutput({tag, " busy"},      32'(busy),     32'd0);
    checkOutput({tag, " init_done"}, 32'(initDone), 32'd0);
  endtask

  // Launches one sequence and walks it through the panel reset handshake.
  task automatic applyStimulus(input logic expectDone);
    expQ.push_back(9'h001);
    expQ.push_back(9'h011);
    expQ.push_back(9'h03A);
    expQ.push_back(9'h155);
    expQ.push_back(9'h036);
    expQ.push_back(9'h148);
    expQ.push_back(9'h029);
    start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    checkOutput("hw_reset ena", 32'(resetEna), 32'd1);
    checkOutput("hw_reset val", 32'(resetVal), 32'd0);
    checkOutput("hw_reset busy", 32'(busy), 32'd1);
    checkOutput("init_done during start", 32'(initDone), 32'(expectDone));
    tick;
    repeat (4) begin
      @(negedge clk);
      checkOutput("wait_rst val", 32'(resetVal), 32'd0);
      checkOutput("wait_rst ena", 32'(resetEna), 32'd0);
      tick;
    end
    resetSent = 1'b1;
    tick;
    resetSent = 1'b0;
    @(negedge clk);
    checkOutput("reset_val released", 32'(resetVal), 32'd1);
    checkOutput("busy after reset", 32'(busy), 32'd1);
  endtask

  task automatic runUntilIdle(input logic [7:0] stallByte, input int stallCycles, input logic startDuringSend);
    int   stalls = 0;
    int   cycles = 0;
    logic pulsed = 1'b0;
    do begin
      tick;
      start = 1'b0;
      if (spiValid && spiData == stallByte && stalls < stallCycles) begin
        spiReady = 1'b0;
        stalls++;
      end else begin
        spiReady = 1'b1;
      end
      if (startDuringSend && !pulsed && spiValid) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      cycles++;
    end while (busy && cycles < 2000);
    start    = 1'b0;
    spiReady = 1'b1;
    checkOutput("sequence within budget", 32'(cycles < 2000), 32'd1);
    @(negedge clk);
    checkOutput("init_done at end", 32'(initDone), 32'd1);
    checkOutput("busy at end", 32'(busy), 32'd0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int waitCycles;
    rst       = 1'b0;
    start     = 1'b0;
    resetSent = 1'b0;
    spiReady  = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    checkResetOutputs("power-on");
    tick;
    rst = 1'b1;

    $display("[TB] plain sequence with ready tied high");
    resetEnaCount = 0;
    stallSeen     = 0;
    applyStimulus(1'b0);
    runUntilIdle(8'h00, 0, 1'b0);
    checkOutput("reset_ena pulse count", 32'(resetEnaCount), 32'd1);
    checkOutput("wait gap after 0x01", 32'(gapMeasured), 32'(EXP_WAIT + 2));
    checkOutput("no stalls", 32'(stallSeen), 32'd0);
    repeat (3) tick;

    $display("[TB] rerun with 7-cycle stall on 0x3A");
    stallSeen = 0;
    applyStimulus(1'b1);
    runUntilIdle(8'h3A, 7, 1'b0);
    checkOutput("stall cycles seen", 32'(stallSeen), 32'd7);
    repeat (3) tick;

    $display("[TB] reset during first DELAY");
    applyStimulus(1'b1);
    waitCycles = 0;
    while (!spiValid && waitCycles < 50) begin
      tick;
      waitCycles++;
    end
    checkOutput("first byte presented", 32'(spiValid), 32'd1);
    tick;
    tick;
    rst = 1'b0;
    tick;
    @(negedge clk);
    checkResetOutputs("abort");
    checkOutput("bytes left after abort", 32'(expQ.size()), 32'd6);
    expQ.delete();
    tick;
    rst = 1'b1;
    repeat (10) tick;
    @(negedge clk);
    checkOutput("idle after abort", 32'(busy), 32'd0);
    gapMeasured = -1;
    applyStimulus(1'b0);
    runUntilIdle(8'h00, 0, 1'b0);
    checkOutput("wait gap after restart", 32'(gapMeasured), 32'(EXP_WAIT + 2));
    repeat (3) tick;

    $display("[TB] stray start during SEND");
    resetEnaCount = 0;
    applyStimulus(1'b1);
    runUntilIdle(8'h00, 0, 1'b1);
    repeat (20) tick;
    @(negedge clk);
    checkOutput("no second run busy", 32'(busy), 32'd0);
    checkOutput("single reset pulse", 32'(resetEnaCount), 32'd1);
    checkOutput("init_done sticky", 32'(initDone), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
